// File: rtl/axis_pkt_pkg.sv
// Shared types and default configuration for the AXI4-Stream packet sink.
package axis_pkt_pkg;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int         DEF_DATA_WIDTH = 8;
    localparam int         DEF_CNT_WIDTH  = 16;
    localparam logic [7:0] DEF_PKT_LEN    = 8'd4;
    localparam logic [7:0] DEF_BP_EVERY   = 8'd0;
    localparam logic [7:0] DEF_BP_CYCLES  = 8'd0;

endpackage

// File: rtl/axis_bp_gen.sv
// Periodic backpressure generator: counts accepted beats and times the stall window.
// `stall` is the stall level for the next cycle, so the caller can register tready from it.
module axis_bp_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       accept,
    input  logic [7:0] cfg_bp_every,
    input  logic [7:0] cfg_bp_cycles,
    input  logic       inhibit,
    output logic       stall
);
    logic [7:0] bp_cnt_r;
    logic [7:0] bp_cnt_next_s;
    logic [7:0] stall_cnt_r;
    logic [7:0] stall_cnt_next_s;
    logic       stall_r;
    logic       bp_en_s;
    logic       count_beat_s;
    logic       hit_s;
    logic       stall_done_s;

    // Beat counting, stall entry and stall expiry.
    always_comb begin
        bp_en_s       = (cfg_bp_every != 8'd0) && (cfg_bp_cycles != 8'd0);
        count_beat_s  = accept && !inhibit && bp_en_s;
        hit_s         = count_beat_s && (({1'b0, bp_cnt_r} + 9'd1) >= {1'b0, cfg_bp_every});
        stall_done_s  = stall_r && (({1'b0, stall_cnt_r} + 9'd1) >= {1'b0, cfg_bp_cycles});
        stall         = hit_s || (stall_r && !stall_done_s);
        bp_cnt_next_s = bp_cnt_r;
        if (hit_s) begin
            bp_cnt_next_s = 8'd0;
        end else if (count_beat_s) begin
            bp_cnt_next_s = bp_cnt_r + 8'd1;
        end else begin
            bp_cnt_next_s = bp_cnt_r;
        end
        stall_cnt_next_s = stall_cnt_r;
        if (hit_s) begin
            stall_cnt_next_s = 8'd0;
        end else if (stall_r) begin
            stall_cnt_next_s = stall_cnt_r + 8'd1;
        end else begin
            stall_cnt_next_s = stall_cnt_r;
        end
    end

    // Counter and stall state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_cnt_r    <= 8'd0;
            stall_cnt_r <= 8'd0;
            stall_r     <= 1'b0;
        end else begin
            bp_cnt_r    <= bp_cnt_next_s;
            stall_cnt_r <= stall_cnt_next_s;
            stall_r     <= stall;
        end
    end

endmodule

// File: rtl/axis_pkt_sink.sv
// AXI4-Stream packet receiver that checks packet length and an incrementing data pattern,
// with programmable periodic backpressure on tready.
module axis_pkt_sink
    import axis_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [7:0]            cfg_pkt_len,
    input  logic [7:0]            cfg_bp_every,
    input  logic [7:0]            cfg_bp_cycles,
    input  logic                  cfg_check_en,
    output logic                  pkt_done,
    output logic                  pkt_ok,
    output logic                  len_err,
    output logic                  data_err,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  err_count
);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t                state_r;
    state_t                state_next_s;
    logic                  tready_r;
    logic [DATA_WIDTH-1:0] exp_data_r;
    logic [7:0]            beat_idx_r;
    logic                  bad_r;
    logic                  pkt_done_r;
    logic                  pkt_ok_r;
    logic                  len_err_r;
    logic                  data_err_r;
    logic [CNT_WIDTH-1:0]  pkt_count_r;
    logic [CNT_WIDTH-1:0]  err_count_r;

    logic       accept_s;
    logic [7:0] beat_num_s;
    logic       len_chk_s;
    logic       in_drain_s;
    logic       mismatch_s;
    logic       short_s;
    logic       long_s;
    logic       pkt_end_s;
    logic       pkt_bad_s;
    logic       inhibit_s;
    logic       stall_s;

    axis_bp_gen u_bp_gen (
        .clk           (clk),
        .reset         (reset),
        .accept        (accept_s),
        .cfg_bp_every  (cfg_bp_every),
        .cfg_bp_cycles (cfg_bp_cycles),
        .inhibit       (inhibit_s),
        .stall         (stall_s)
    );

    // Per-beat decode and next-state selection; long violations beat backpressure.
    always_comb begin
        accept_s     = s_axis_tvalid && tready_r;
        beat_num_s   = (beat_idx_r == 8'hFF) ? 8'hFF : (beat_idx_r + 8'd1);
        len_chk_s    = (cfg_pkt_len != 8'd0);
        in_drain_s   = (state_r == DRAIN);
        mismatch_s   = accept_s && !in_drain_s && cfg_check_en && (s_axis_tdata != exp_data_r);
        short_s      = accept_s && !in_drain_s && s_axis_tlast && len_chk_s && (beat_num_s < cfg_pkt_len);
        long_s       = accept_s && !in_drain_s && !s_axis_tlast && len_chk_s && (beat_num_s >= cfg_pkt_len);
        pkt_end_s    = accept_s && s_axis_tlast;
        pkt_bad_s    = bad_r || mismatch_s || short_s || in_drain_s;
        inhibit_s    = in_drain_s || long_s;
        state_next_s = state_r;
        case (state_r)
            RECV: begin
                if (long_s) begin
                    state_next_s = DRAIN;
                end else if (stall_s) begin
                    state_next_s = STALL;
                end else begin
                    state_next_s = RECV;
                end
            end
            STALL: begin
                if (stall_s) begin
                    state_next_s = STALL;
                end else begin
                    state_next_s = RECV;
                end
            end
            DRAIN: begin
                if (pkt_end_s) begin
                    state_next_s = RECV;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = RECV;
        endcase
    end

    // State, ready, reference data, per-packet tracking, status pulses and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= RECV;
            tready_r    <= 1'b0;
            exp_data_r  <= {DATA_WIDTH{1'b0}};
            beat_idx_r  <= 8'd0;
            bad_r       <= 1'b0;
            pkt_done_r  <= 1'b0;
            pkt_ok_r    <= 1'b0;
            len_err_r   <= 1'b0;
            data_err_r  <= 1'b0;
            pkt_count_r <= {CNT_WIDTH{1'b0}};
            err_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r    <= state_next_s;
            tready_r   <= (state_next_s != STALL);
            pkt_done_r <= pkt_end_s;
            pkt_ok_r   <= pkt_end_s && !pkt_bad_s;
            len_err_r  <= short_s || long_s;
            data_err_r <= mismatch_s;
            // A mismatch resynchronises the reference to the received value.
            if (mismatch_s) begin
                exp_data_r <= s_axis_tdata + DATA_ONE;
            end else if (accept_s) begin
                exp_data_r <= exp_data_r + DATA_ONE;
            end else begin
                exp_data_r <= exp_data_r;
            end
            if (pkt_end_s) begin
                beat_idx_r <= 8'd0;
                bad_r      <= 1'b0;
            end else if (accept_s) begin
                beat_idx_r <= beat_num_s;
                bad_r      <= bad_r || mismatch_s || long_s;
            end else begin
                beat_idx_r <= beat_idx_r;
                bad_r      <= bad_r;
            end
            if (pkt_end_s && (pkt_count_r != CNT_MAX)) begin
                pkt_count_r <= pkt_count_r + CNT_ONE;
            end else begin
                pkt_count_r <= pkt_count_r;
            end
            if (pkt_end_s && pkt_bad_s && (err_count_r != CNT_MAX)) begin
                err_count_r <= err_count_r + CNT_ONE;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign pkt_done      = pkt_done_r;
    assign pkt_ok        = pkt_ok_r;
    assign len_err       = len_err_r;
    assign data_err      = data_err_r;
    assign pkt_count     = pkt_count_r;
    assign err_count     = err_count_r;

endmodule

// File: tb/tb_axis_pkt_sink.sv
// Randomised self-checking bench for axis_pkt_sink against a packet-level reference model.
module tb_axis_pkt_sink;
    localparam int DW = 8;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_axis_tdata = 8'd0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [7:0]    cfg_pkt_len = 8'd4;
    logic [7:0]    cfg_bp_every = 8'd0;
    logic [7:0]    cfg_bp_cycles = 8'd0;
    logic          cfg_check_en = 1'b1;
    logic          pkt_done, pkt_ok, len_err, data_err;
    logic [CW-1:0] pkt_count, err_count;

    always #5 clk = ~clk;

    axis_pkt_sink #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .cfg_pkt_len(cfg_pkt_len), .cfg_bp_every(cfg_bp_every),
        .cfg_bp_cycles(cfg_bp_cycles), .cfg_check_en(cfg_check_en),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .len_err(len_err), .data_err(data_err),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: what the sink should have seen and be doing.
    logic          m_ready;
    logic [DW-1:0] m_exp;
    int            m_beats;
    logic          m_bad, m_drain, m_acc;
    int            m_bp, m_stall_left;
    logic [CW-1:0] m_pkt, m_err;
    logic          e_done, e_ok, e_len, e_data;

    wire [4+2*CW:0] obs = {s_axis_tready, pkt_done, pkt_ok, len_err, data_err, pkt_count, err_count};

    function automatic logic [4+2*CW:0] exp_vec();
        return {m_ready, e_done, e_ok, e_len, e_data, m_pkt, m_err};
    endfunction

    task automatic model_reset();
        m_ready = 1'b0; m_exp = 8'd0; m_beats = 0; m_bad = 1'b0; m_drain = 1'b0;
        m_acc = 1'b0; m_bp = 0; m_stall_left = 0; m_pkt = 6'd0; m_err = 6'd0;
        e_done = 1'b0; e_ok = 1'b0; e_len = 1'b0; e_data = 1'b0;
    endtask

    // Drive one cycle and advance the model by the rules of the sink.
    task automatic beat_step(input logic v, input logic [DW-1:0] d, input logic l);
        logic acc, mism, is_long;
        s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l;
        acc = v && m_ready;
        @(posedge clk);
        #1;
        e_done = 1'b0; e_ok = 1'b0; e_len = 1'b0; e_data = 1'b0; m_acc = acc;
        if (!m_ready) begin
            if (m_stall_left > 0) m_stall_left--;
        end else if (acc) begin
            m_beats++;
            if (m_drain) begin
                m_exp = m_exp + 8'd1;
                if (l) m_drain = 1'b0;
            end else begin
                mism = cfg_check_en && (d != m_exp);
                m_exp = mism ? d + 8'd1 : m_exp + 8'd1;
                if (mism) begin e_data = 1'b1; m_bad = 1'b1; end
                is_long = (cfg_pkt_len != 8'd0) && !l && (m_beats == int'(cfg_pkt_len));
                if ((cfg_pkt_len != 8'd0) && l && (m_beats < int'(cfg_pkt_len))) begin
                    e_len = 1'b1; m_bad = 1'b1;
                end
                if (is_long) begin e_len = 1'b1; m_bad = 1'b1; m_drain = 1'b1; end
                if (!is_long && cfg_bp_every != 8'd0 && cfg_bp_cycles != 8'd0) begin
                    m_bp++;
                    if (m_bp >= int'(cfg_bp_every)) begin m_bp = 0; m_stall_left = int'(cfg_bp_cycles); end
                end
            end
            if (l) begin
                e_done = 1'b1; e_ok = !m_bad;
                if (m_pkt != 6'h3F) m_pkt = m_pkt + 6'd1;
                if (m_bad && m_err != 6'h3F) m_err = m_err + 6'd1;
                m_bad = 1'b0; m_beats = 0;
            end
        end
        m_ready = (m_stall_left == 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL reset_state got=%h want=%h", obs, exp_vec()); end
        beat_step(1'b0, 8'd0, 1'b0);
        checks++;
        if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_tready_rise got=%b want=1", s_axis_tready); end
    endtask

    task automatic test_good_pkt();
        int guard;
        do_reset();
        cfg_pkt_len = 8'd4; cfg_bp_every = 8'd0; cfg_bp_cycles = 8'd0; cfg_check_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            do begin
                beat_step(1'b1, 8'(i), i == 3); guard++; checks++;
                if (obs !== exp_vec()) begin failures++; $display("FAIL good_pkt beat=%0d got=%h want=%h", i, obs, exp_vec()); end
            end while (!m_acc && guard < 16);
        end
        checks++;
        if (pkt_done !== 1'b1 || pkt_ok !== 1'b1 || pkt_count !== 6'd1 || err_count !== 6'd0)
            begin failures++; $display("FAIL good_pkt_end got=%b%b/%0d/%0d want=11/1/0", pkt_done, pkt_ok, pkt_count, err_count); end
    endtask

    task automatic test_short_pkt();
        int guard;
        logic [7:0] d;
        do_reset();
        cfg_pkt_len = 8'd4; cfg_check_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            d = 8'(i);
            guard = 0;
            do begin
                beat_step(1'b1, d, (i == 2) || (i == 6)); guard++; checks++;
                if (obs !== exp_vec()) begin failures++; $display("FAIL short_pkt beat=%0d got=%h want=%h", i, obs, exp_vec()); end
            end while (!m_acc && guard < 16);
            if (i == 2) begin
                checks++;
                if (len_err !== 1'b1 || pkt_ok !== 1'b0) begin failures++; $display("FAIL short_len_err got=%b%b want=10", len_err, pkt_ok); end
            end
        end
        checks++;
        if (pkt_count !== 6'd2 || err_count !== 6'd1 || pkt_ok !== 1'b1)
            begin failures++; $display("FAIL short_counts got=%0d/%0d/%b want=2/1/1", pkt_count, err_count, pkt_ok); end
    endtask

    task automatic test_long_pkt();
        int guard, lerr_seen;
        do_reset();
        cfg_pkt_len = 8'd4; cfg_check_en = 1'b1;
        lerr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            guard = 0;
            do begin
                beat_step(1'b1, 8'(i), i == 5); guard++; checks++;
                if (obs !== exp_vec()) begin failures++; $display("FAIL long_pkt beat=%0d got=%h want=%h", i, obs, exp_vec()); end
                lerr_seen += int'(len_err);
            end while (!m_acc && guard < 16);
        end
        checks++;
        if (lerr_seen != 1 || pkt_count !== 6'd1 || err_count !== 6'd1 || pkt_ok !== 1'b0)
            begin failures++; $display("FAIL long_counts got=%0d/%0d/%0d want=1/1/1", lerr_seen, pkt_count, err_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] nd;
        int acc_cnt;
        do_reset();
        cfg_pkt_len = 8'd0; cfg_bp_every = 8'd2; cfg_bp_cycles = 8'd3; cfg_check_en = 1'b1;
        nd = 8'd0; acc_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            beat_step(1'b1, nd, nd[1:0] == 2'b11);
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL bp_cycle k=%0d got=%h want=%h", k, obs, exp_vec()); end
            checks++;
            if (s_axis_tready !== (((k - 1) % 5) < 2)) begin failures++; $display("FAIL bp_pattern k=%0d got=%b", k, s_axis_tready); end
            if (m_acc) begin nd = nd + 8'd1; acc_cnt++; end
        end
        checks++;
        if (int'(pkt_count) != acc_cnt / 4 || err_count !== 6'd0)
            begin failures++; $display("FAIL bp_counts got=%0d/%0d want=%0d/0", pkt_count, err_count, acc_cnt / 4); end
        cfg_bp_every = 8'd0; cfg_bp_cycles = 8'd0;
    endtask

    task automatic test_data_err();
        int guard, derr_seen;
        logic [7:0] d;
        do_reset();
        cfg_pkt_len = 8'd4; cfg_check_en = 1'b1;
        derr_seen = 0;
        for (int i = 0; i < 8; i++) begin
            d = (i == 0) ? 8'h00 : 8'h54 + 8'(i);
            guard = 0;
            do begin
                beat_step(1'b1, d, (i == 3) || (i == 7)); guard++; checks++;
                if (obs !== exp_vec()) begin failures++; $display("FAIL data_err beat=%0d got=%h want=%h", i, obs, exp_vec()); end
                derr_seen += int'(data_err);
            end while (!m_acc && guard < 16);
        end
        checks++;
        if (derr_seen != 1 || pkt_count !== 6'd2 || err_count !== 6'd1)
            begin failures++; $display("FAIL data_err_counts got=%0d/%0d/%0d want=1/2/1", derr_seen, pkt_count, err_count); end
    endtask

    task automatic test_reset_mid();
        int guard;
        for (int i = 0; i < 2; i++) begin
            guard = 0;
            do begin
                beat_step(1'b1, m_exp, 1'b0); guard++; checks++;
                if (obs !== exp_vec()) begin failures++; $display("FAIL mid_pre beat=%0d got=%h want=%h", i, obs, exp_vec()); end
            end while (!m_acc && guard < 16);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== 1'b0 || pkt_count !== 6'd0 || err_count !== 6'd0)
            begin failures++; $display("FAIL mid_async got=%b/%0d/%0d want=0/0/0", s_axis_tready, pkt_count, err_count); end
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            do begin
                beat_step(1'b1, 8'(i), i == 3); guard++; checks++;
                if (obs !== exp_vec()) begin failures++; $display("FAIL mid_post beat=%0d got=%h want=%h", i, obs, exp_vec()); end
            end while (!m_acc && guard < 16);
        end
        checks++;
        if (pkt_ok !== 1'b1 || pkt_count !== 6'd1 || err_count !== 6'd0)
            begin failures++; $display("FAIL mid_post_end got=%b/%0d/%0d want=1/1/0", pkt_ok, pkt_count, err_count); end
    endtask

    task automatic test_random();
        int guard, n, lo;
        logic [7:0] d;
        for (int p = 0; p < 40; p++) begin
            guard = 0;
            while (!m_ready && guard < 300) begin
                beat_step(1'b0, 8'd0, 1'b0); guard++; checks++;
                if (obs !== exp_vec()) begin failures++; $display("FAIL rand_idle got=%h want=%h", obs, exp_vec()); end
            end
            cfg_pkt_len   = 8'($urandom_range(0, 6));
            cfg_bp_every  = 8'($urandom_range(0, 3));
            cfg_bp_cycles = 8'($urandom_range(0, 3));
            cfg_check_en  = ($urandom_range(0, 3) != 0);
            lo = (cfg_pkt_len > 8'd1) ? int'(cfg_pkt_len) - 1 : 1;
            n  = (cfg_pkt_len == 8'd0) ? int'($urandom_range(1, 6)) : int'($urandom_range(lo, int'(cfg_pkt_len) + 2));
            for (int i = 0; i < n; i++) begin
                d = ($urandom_range(0, 7) == 0) ? (m_exp ^ 8'h5A) : m_exp;
                guard = 0;
                do begin
                    if ($urandom_range(0, 3) == 0) beat_step(1'b0, d, 1'b0);
                    else beat_step(1'b1, d, i == n - 1);
                    guard++; checks++;
                    if (obs !== exp_vec()) begin failures++; $display("FAIL rand pkt=%0d beat=%0d got=%h want=%h", p, i, obs, exp_vec()); end
                end while (!m_acc && guard < 64);
                if (!m_acc) begin failures++; $display("FAIL rand_timeout pkt=%0d beat=%0d", p, i); end
            end
        end
    endtask

    task automatic test_saturation();
        int guard;
        cfg_pkt_len = 8'd0; cfg_bp_every = 8'd0; cfg_bp_cycles = 8'd0; cfg_check_en = 1'b1;
        for (int p = 0; p < 70; p++) begin
            guard = 0;
            do begin
                beat_step(1'b1, m_exp ^ 8'h80, 1'b1); guard++; checks++;
                if (obs !== exp_vec()) begin failures++; $display("FAIL sat pkt=%0d got=%h want=%h", p, obs, exp_vec()); end
            end while (!m_acc && guard < 16);
        end
        checks++;
        if (pkt_count !== 6'h3F || err_count !== 6'h3F)
            begin failures++; $display("FAIL sat_counts got=%0d/%0d want=63/63", pkt_count, err_count); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_pkt();
        test_short_pkt();
        test_long_pkt();
        test_backpressure();
        test_data_err();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
